// File: rtl/fpu_wb_if.sv
// Writeback bus for fpu_wb: FPU result/handshake inputs and the vector/scalar
// register-file write ports.
interface fpu_wb_if;
    logic         fpu_done;
    logic         VADD;
    logic         VDOT;
    logic         SMUL;
    logic [255:0] Vout;
    logic [15:0]  Sout;
    logic         V;
    logic [15:0]  Instruction;
    logic [2:0]   vdst;
    logic [2:0]   sdst;
    logic         wb_ready;
    logic         vrf_we;
    logic [2:0]   vrf_waddr;
    logic [255:0] vrf_wdata;
    logic         srf_we;
    logic [2:0]   srf_waddr;
    logic [15:0]  srf_wdata;

    modport slave (
        input  fpu_done, VADD, VDOT, SMUL, Vout, Sout, V, Instruction, vdst, sdst,
        output wb_ready, vrf_we, vrf_waddr, vrf_wdata, srf_we, srf_waddr, srf_wdata
    );

    modport master (
        output fpu_done, VADD, VDOT, SMUL, Vout, Sout, V, Instruction, vdst, sdst,
        input  wb_ready, vrf_we, vrf_waddr, vrf_wdata, srf_we, srf_waddr, srf_wdata
    );
endinterface

// File: rtl/fpu_wb.sv
// FPU writeback sequencer: registers a result and issues vector/scalar writes,
// plus an overflow write of the instruction word. Option: FPU_WB_STICKY_OVF_EN.
module fpu_wb #(
    parameter logic [2:0] OVF_REG = 3'd7
) (
    input  logic     clk,
    input  logic     rst_n,
    fpu_wb_if.slave  bus
`ifdef FPU_WB_STICKY_OVF_EN
    ,
    output logic     ovf_sticky,
    input  logic     ovf_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB_VEC = 2'd1,
        WB_SCL = 2'd2,
        WB_OVF = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   vout_q;
    logic [15:0]    sout_q;
    logic [15:0]    instr_q;
    logic [2:0]     vdst_q;
    logic [2:0]     sdst_q;
    logic           ovf_q;

    logic [2:0]     op;
    logic           onehot;
    logic           ready;
    logic           accept;
    logic           ovf_c;

    logic           vrf_we;
    logic [2:0]     vrf_waddr;
    logic [255:0]   vrf_wdata;
    logic           srf_we;
    logic [2:0]     srf_waddr;
    logic [15:0]    srf_wdata;

    assign op     = {bus.VADD, bus.VDOT, bus.SMUL};
    assign onehot = (op == 3'b100) || (op == 3'b010) || (op == 3'b001);
    assign ovf_c  = bus.V & (bus.VADD | bus.SMUL);
    // Only a pending overflow write blocks a new accept.
    assign ready  = !(((state_q == WB_VEC) || (state_q == WB_SCL)) && ovf_q);
    assign accept = bus.fpu_done & ready & onehot;

    always_comb begin
        state_d = IDLE;
        if (!ready) begin
            state_d = WB_OVF;
        end else if (accept) begin
            state_d = bus.SMUL ? WB_SCL : WB_VEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vout_q  <= '0;
            sout_q  <= '0;
            instr_q <= '0;
            vdst_q  <= '0;
            sdst_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vout_q  <= bus.Vout;
                sout_q  <= bus.Sout;
                instr_q <= bus.Instruction;
                vdst_q  <= bus.vdst;
                sdst_q  <= bus.sdst;
                ovf_q   <= ovf_c;
            end
        end
    end

    always_comb begin
        vrf_we    = 1'b0;
        vrf_waddr = '0;
        vrf_wdata = '0;
        srf_we    = 1'b0;
        srf_waddr = '0;
        srf_wdata = '0;
        case (state_q)
            WB_VEC: begin
                vrf_we    = 1'b1;
                vrf_waddr = vdst_q;
                vrf_wdata = vout_q;
            end
            WB_SCL: begin
                srf_we    = 1'b1;
                srf_waddr = sdst_q;
                srf_wdata = sout_q;
            end
            WB_OVF: begin
                srf_we    = 1'b1;
                srf_waddr = OVF_REG;
                srf_wdata = instr_q;
            end
            default: ;
        endcase
    end

    assign bus.wb_ready  = ready;
    assign bus.vrf_we    = vrf_we;
    assign bus.vrf_waddr = vrf_waddr;
    assign bus.vrf_wdata = vrf_wdata;
    assign bus.srf_we    = srf_we;
    assign bus.srf_waddr = srf_waddr;
    assign bus.srf_wdata = srf_wdata;

`ifdef FPU_WB_STICKY_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (state_q == WB_OVF) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_wb.sv
// Directed-vector bench for fpu_wb: table of single ops plus hand-written
// reset, back-to-back and overflow-stall sequences.
module tb_fpu_wb;

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nerr;

    fpu_wb_if bus ();

`ifdef FPU_WB_STICKY_OVF_EN
    logic ovf_sticky;
    logic ovf_clr;
    fpu_wb #(.OVF_REG(3'd7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );
`else
    fpu_wb #(.OVF_REG(3'd7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vadd, vdot, smul, v;
        logic [2:0]  vdst, sdst;
        logic [15:0] lane, sout, instr;
        logic        e1_vwe;
        logic [2:0]  e1_va;
        logic        e1_swe;
        logic [2:0]  e1_sa;
        logic [15:0] e1_sd;
        logic        e1_rdy;
        logic        e2_swe;
        logic [2:0]  e2_sa;
        logic [15:0] e2_sd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input logic vadd, input logic vdot, input logic smul, input logic v,
                           input logic [2:0] vdst, input logic [2:0] sdst, input logic [15:0] lane,
                           input logic [15:0] sout, input logic [15:0] instr);
        bus.VADD        = vadd;
        bus.VDOT        = vdot;
        bus.SMUL        = smul;
        bus.V           = v;
        bus.vdst        = vdst;
        bus.sdst        = sdst;
        bus.Vout        = {16{lane}};
        bus.Sout        = sout;
        bus.Instruction = instr;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".vrf_we"},    256'(bus.vrf_we),    256'(1'b0));
        chk({nm, ".vrf_waddr"}, 256'(bus.vrf_waddr), 256'(3'd0));
        chk({nm, ".vrf_wdata"}, bus.vrf_wdata,       '0);
        chk({nm, ".srf_we"},    256'(bus.srf_we),    256'(1'b0));
        chk({nm, ".srf_waddr"}, 256'(bus.srf_waddr), 256'(3'd0));
        chk({nm, ".srf_wdata"}, 256'(bus.srf_wdata), 256'(16'h0));
        chk({nm, ".wb_ready"},  256'(bus.wb_ready),  256'(1'b1));
    endtask

    initial begin
        logic [255:0] exp_vd;
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.fpu_done = 1'b0;
        set_ops(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
`ifdef FPU_WB_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        //          vadd  vdot  smul  v     vdst  sdst  lane      sout      instr     e1:vwe va    swe   sa    sd        rdy   e2:swe sa   sd
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd5, 16'h3C00, 16'h1111, 16'h9999, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 16'h5555, 16'h7BFF, 16'hA123, 1'b0, 3'd0, 1'b1, 3'd2, 16'h7BFF, 1'b0, 1'b1, 3'd7, 16'hA123};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 3'd4, 16'h1234, 16'h4444, 16'h7777, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 16'h4000, 16'h2222, 16'hBEEF, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd4, 16'h0F0F, 16'h5555, 16'h6666, 1'b0, 3'd0, 1'b1, 3'd4, 16'h5555, 1'b1, 1'b0, 3'd0, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd7, 16'hAAAA, 16'h1111, 16'h2222, 1'b0, 3'd0, 1'b1, 3'd7, 16'h1111, 1'b0, 1'b1, 3'd7, 16'h2222};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd3, 16'hFFFF, 16'h3333, 16'h4444, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 16'h8888, 16'h5A5A, 16'hA5A5, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000};

        #2;
        chk_quiet("reset");
`ifdef FPU_WB_STICKY_OVF_EN
        chk("reset.ovf_sticky", 256'(ovf_sticky), 256'(1'b0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_ops(vecs[i].vadd, vecs[i].vdot, vecs[i].smul, vecs[i].v, vecs[i].vdst,
                    vecs[i].sdst, vecs[i].lane, vecs[i].sout, vecs[i].instr);
            bus.fpu_done = 1'b1;
            @(posedge clk);
            #1;
            bus.fpu_done = 1'b0;
            exp_vd = vecs[i].e1_vwe ? {16{vecs[i].lane}} : '0;
            chk($sformatf("v%0d.n1.vrf_we", i),    256'(bus.vrf_we),    256'(vecs[i].e1_vwe));
            chk($sformatf("v%0d.n1.vrf_waddr", i), 256'(bus.vrf_waddr), 256'(vecs[i].e1_va));
            chk($sformatf("v%0d.n1.vrf_wdata", i), bus.vrf_wdata,       exp_vd);
            chk($sformatf("v%0d.n1.srf_we", i),    256'(bus.srf_we),    256'(vecs[i].e1_swe));
            chk($sformatf("v%0d.n1.srf_waddr", i), 256'(bus.srf_waddr), 256'(vecs[i].e1_sa));
            chk($sformatf("v%0d.n1.srf_wdata", i), 256'(bus.srf_wdata), 256'(vecs[i].e1_sd));
            chk($sformatf("v%0d.n1.wb_ready", i),  256'(bus.wb_ready),  256'(vecs[i].e1_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.n2.vrf_we", i),    256'(bus.vrf_we),    256'(1'b0));
            chk($sformatf("v%0d.n2.srf_we", i),    256'(bus.srf_we),    256'(vecs[i].e2_swe));
            chk($sformatf("v%0d.n2.srf_waddr", i), 256'(bus.srf_waddr), 256'(vecs[i].e2_sa));
            chk($sformatf("v%0d.n2.srf_wdata", i), 256'(bus.srf_wdata), 256'(vecs[i].e2_sd));
            chk($sformatf("v%0d.n2.wb_ready", i),  256'(bus.wb_ready),  256'(1'b1));
            @(posedge clk);
            #1;
            chk_quiet($sformatf("v%0d.n3", i));
        end

        // Reset while a vector write is on the bus
        @(negedge clk);
        set_ops(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 16'hC0DE, 16'h0, 16'h0);
        bus.fpu_done = 1'b1;
        @(posedge clk);
        #1;
        bus.fpu_done = 1'b0;
        chk("rstvec.pre.vrf_we", 256'(bus.vrf_we), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk_quiet("rstvec.post");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the first SMUL write drops the pending overflow write
        @(negedge clk);
        set_ops(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd3, 16'h0, 16'h1357, 16'h2468);
        bus.fpu_done = 1'b1;
        @(posedge clk);
        #1;
        bus.fpu_done = 1'b0;
        chk("rstovf.pre.srf_we", 256'(bus.srf_we), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk_quiet("rstovf.mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("rstovf.after");

        // Four back-to-back VADDs, then VADD with overflow and an SMUL that must stall one cycle
        @(negedge clk);
        set_ops(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h1000, 16'h0, 16'h0);
        bus.fpu_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d.vrf_we", k),    256'(bus.vrf_we),    256'(1'b1));
            chk($sformatf("b2b%0d.vrf_waddr", k), 256'(bus.vrf_waddr), 256'(3'(k)));
            chk($sformatf("b2b%0d.vrf_wdata", k), bus.vrf_wdata,       {16{16'(16'h1000 + k)}});
            chk($sformatf("b2b%0d.wb_ready", k),  256'(bus.wb_ready),  256'(1'b1));
            if (k < 3) begin
                set_ops(1'b1, 1'b0, 1'b0, 1'b0, 3'(k + 1), 3'd0, 16'(16'h1000 + k + 1), 16'h0, 16'h0);
            end else begin
                set_ops(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 16'h2000, 16'h0, 16'hCAFE);
            end
        end
        @(posedge clk);
        #1;
        chk("stall.c1.vrf_we",   256'(bus.vrf_we),    256'(1'b1));
        chk("stall.c1.vrf_waddr", 256'(bus.vrf_waddr), 256'(3'd5));
        chk("stall.c1.wb_ready", 256'(bus.wb_ready),  256'(1'b0));
        set_ops(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 16'h0, 16'h0ABC, 16'hDEAD);
        @(posedge clk);
        #1;
        chk("stall.c2.srf_we",    256'(bus.srf_we),    256'(1'b1));
        chk("stall.c2.srf_waddr", 256'(bus.srf_waddr), 256'(3'd7));
        chk("stall.c2.srf_wdata", 256'(bus.srf_wdata), 256'(16'hCAFE));
        chk("stall.c2.wb_ready",  256'(bus.wb_ready),  256'(1'b1));
        chk("stall.c2.vrf_we",    256'(bus.vrf_we),    256'(1'b0));
        @(posedge clk);
        #1;
        bus.fpu_done = 1'b0;
        chk("stall.c3.srf_we",    256'(bus.srf_we),    256'(1'b1));
        chk("stall.c3.srf_waddr", 256'(bus.srf_waddr), 256'(3'd3));
        chk("stall.c3.srf_wdata", 256'(bus.srf_wdata), 256'(16'h0ABC));
        chk("stall.c3.wb_ready",  256'(bus.wb_ready),  256'(1'b1));
        @(posedge clk);
        #1;
        chk_quiet("stall.c4");

`ifdef FPU_WB_STICKY_OVF_EN
        chk("sticky.set", 256'(ovf_sticky), 256'(1'b1));
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("sticky.clr", 256'(ovf_sticky), 256'(1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
